// File: rtl/instr_mem_sync.sv
// Synchronous byte-addressed instruction memory for the fetch stage.
// Big-endian words are assembled from BPW consecutive cells, and cell
// indices wrap modulo MEM_BYTES. A registered fetch port has a hold input.
// A word-wide program-load port has byte enables. After every reset, an
// init sequencer zeroes the whole array.
//
// Port behaviour:
//   - fetch_en and hold are level signals sampled at each rising edge.
//     fetch_en asks for a read of the word at addr. hold freezes the
//     output registers and takes priority over fetch_en.
//   - ld_en is a write strobe sampled at each rising edge.
//   - There is no back-pressure on either port. While busy=1, both
//     fetch and load requests are ignored, and loads are lost.
module instr_mem_sync #(
  parameter int WORD_LEN  = 32,
  parameter int CELL_SIZE = 8,
  parameter int MEM_BYTES = 1024
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            fetch_en,
  input  logic                            hold,
  input  logic [WORD_LEN-1:0]             addr,
  output logic [WORD_LEN-1:0]             instruction,
  output logic                            instr_valid,
  output logic                            misaligned,
  output logic                            busy,
  input  logic                            ld_en,
  input  logic [WORD_LEN-1:0]             ld_addr,
  input  logic [WORD_LEN-1:0]             ld_data,
  input  logic [WORD_LEN/CELL_SIZE-1:0]   ld_be
);

  localparam int BPW   = WORD_LEN / CELL_SIZE;
  localparam int AW    = $clog2(MEM_BYTES);
  localparam int WORDS = MEM_BYTES / BPW;
  localparam int CW    = $clog2(WORDS);

  // CLEAR zeroes one word per cycle. RUN serves fetches and loads.
  // busy is the externally visible copy of this state.
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [CW-1:0]           clr_ptr_q, clr_ptr_d;
  logic                    clr_we;
  logic                    ld_we;

  logic [CELL_SIZE-1:0]    mem_q [MEM_BYTES];

  logic [AW-1:0]           fetch_base;
  logic [AW-1:0]           load_base;
  logic [AW-1:0]           clr_base;
  logic [WORD_LEN-1:0]     rd_word;
  logic                    rd_misaligned;

  logic [WORD_LEN-1:0]     instr_q, instr_d;
  logic                    valid_q, valid_d;
  logic                    mis_q, mis_d;

  // Address bits above AW are deliberately ignored.
  logic                    unused_addr_hi;
  assign unused_addr_hi = ^{addr[WORD_LEN-1:AW], ld_addr[WORD_LEN-1:AW]};

  assign fetch_base = addr[AW-1:0];
  assign load_base  = ld_addr[AW-1:0];
  assign clr_base   = AW'(clr_ptr_q) * AW'(BPW);

  // State register and clear pointer. Reset always restarts CLEAR at word 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_CLEAR;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  // Next state: walk through every word once, then stay in RUN until reset.
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    clr_we    = 1'b0;
    ld_we     = 1'b0;
    unique case (state_q)
      ST_CLEAR: begin
        clr_we    = 1'b1;
        clr_ptr_d = clr_ptr_q + CW'(1);
        if (clr_ptr_q == CW'(WORDS - 1)) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        ld_we = ld_en;
      end
      default: begin
        state_d = ST_CLEAR;
      end
    endcase
  end

  assign busy = (state_q == ST_CLEAR);

  // Big-endian word read: the cell at the base address is the MSB byte.
  // Cell indices wrap naturally in AW bits.
  always_comb begin
    rd_word = '0;
    for (int j = 0; j < BPW; j++) begin
      rd_word[(BPW-1-j)*CELL_SIZE +: CELL_SIZE] = mem_q[fetch_base + AW'(j)];
    end
  end

  assign rd_misaligned = (fetch_base & AW'(BPW - 1)) != '0;

  // Memory array write port. The array has no reset; CLEAR initialises it.
  // The read above uses the pre-edge contents, so a fetch and a load in the
  // same cycle behave read-first.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (clr_we) begin
        for (int i = 0; i < BPW; i++) begin
          mem_q[clr_base + AW'(i)] <= '0;
        end
      end else if (ld_we) begin
        for (int i = 0; i < BPW; i++) begin
          if (ld_be[i]) begin
            mem_q[load_base + AW'(BPW - 1 - i)] <= ld_data[i*CELL_SIZE +: CELL_SIZE];
          end
        end
      end
    end
  end

  // Fetch output next-value logic.
  // - In CLEAR, the outputs are forced to their idle values.
  // - hold freezes the outputs.
  // - An idle cycle (no fetch) only drops valid.
  always_comb begin
    instr_d = instr_q;
    valid_d = valid_q;
    mis_d   = mis_q;
    if (state_q != ST_RUN) begin
      instr_d = '0;
      valid_d = 1'b0;
    end else if (!hold) begin
      if (fetch_en) begin
        instr_d = rd_word;
        valid_d = 1'b1;
        mis_d   = rd_misaligned;
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  // Fetch output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q <= '0;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      instr_q <= instr_d;
      valid_q <= valid_d;
      mis_q   <= mis_d;
    end
  end

  assign instruction = instr_q;
  assign instr_valid = valid_q;
  assign misaligned  = mis_q;

endmodule

// File: tb/tb_instr_mem_sync.sv
// Directed bench for instr_mem_sync.
// Inputs are driven and outputs are sampled on the falling edge, so each
// check sees the result of the preceding rising edge.
module tb_instr_mem_sync;

  logic        clk;
  logic        rst;
  logic        fetch_en;
  logic        hold;
  logic [31:0] addr;
  logic [31:0] instruction;
  logic        instr_valid;
  logic        misaligned;
  logic        busy;
  logic        ld_en;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;
  logic [3:0]  ld_be;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  instr_mem_sync dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_en    (fetch_en),
    .hold        (hold),
    .addr        (addr),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .misaligned  (misaligned),
    .busy        (busy),
    .ld_en       (ld_en),
    .ld_addr     (ld_addr),
    .ld_data     (ld_data),
    .ld_be       (ld_be)
  );

  // Clock and watchdog.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_load(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    ld_en    = 1'b1;
    ld_addr  = a;
    ld_data  = d;
    ld_be    = be;
    fetch_en = 1'b0;
    tick();
    ld_en    = 1'b0;
  endtask

  task automatic do_fetch(input string tag, input logic [31:0] a,
                          input logic [31:0] exp_word, input logic exp_mis);
    exp_q.push_back(exp_word);
    fetch_en = 1'b1;
    addr     = a;
    tick();
    fetch_en = 1'b0;
    check_eq({tag, "_instr"}, instruction, exp_q.pop_front());
    check_eq({tag, "_valid"}, 32'(instr_valid), 32'd1);
    check_eq({tag, "_mis"}, 32'(misaligned), 32'(exp_mis));
  endtask

  // Counts the cycles for which busy stays high, with a bound on the loop.
  // It also counts any cycle in that window where the outputs are not idle.
  // When drop_ld is set, a load to address 8 is driven during the early
  // part of the clear; that load must be discarded.
  task automatic wait_clear(input logic drop_ld, output int cycles, output int bad);
    cycles = 0;
    bad    = 0;
    while (busy === 1'b1 && cycles < 2000) begin
      cycles++;
      if (instr_valid !== 1'b0 || instruction !== 32'h0) bad++;
      ld_en   = drop_ld && (cycles < 200);
      ld_addr = 32'd8;
      ld_data = 32'hFFFF_FFFF;
      ld_be   = 4'hF;
      tick();
    end
    ld_en = 1'b0;
  endtask

  initial begin
    int cyc;
    int bad;
    rst = 1'b0; fetch_en = 1'b0; hold = 1'b0; addr = '0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0; ld_be = '0;
    @(negedge clk);

    // Init clear: one reset cycle, then fetch address 0 on every cycle.
    rst = 1'b1;
    tick();
    check_eq("rst_instr", instruction, 32'h0);
    check_eq("rst_valid", 32'(instr_valid), 32'd0);
    check_eq("rst_mis", 32'(misaligned), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    fetch_en = 1'b1;
    addr = 32'd0;
    wait_clear(1'b0, cyc, bad);
    check_eq("init_busy_cycles", 32'(cyc), 32'd256);
    check_eq("init_outputs_idle", 32'(bad), 32'd0);
    check_eq("run_entry_valid", 32'(instr_valid), 32'd0);
    tick();
    check_eq("first_fetch_instr", instruction, 32'h0);
    check_eq("first_fetch_valid", 32'(instr_valid), 32'd1);
    fetch_en = 1'b0;

    // Basic load followed by a fetch.
    do_load(32'd0, 32'h8020_000A, 4'hF);
    check_eq("idle_valid_drop", 32'(instr_valid), 32'd0);
    check_eq("idle_instr_keep", instruction, 32'h0);
    do_fetch("basic", 32'd0, 32'h8020_000A, 1'b0);

    // Partial write using byte enables.
    do_load(32'd0, 32'hAABB_CCDD, 4'b0101);
    do_fetch("byte_en", 32'd0, 32'h80BB_00DD, 1'b0);

    // Wrap at the top of memory, with a misaligned fetch.
    do_load(32'd1020, 32'h1122_3344, 4'hF);
    do_load(32'd0, 32'h5566_7788, 4'hF);
    do_fetch("wrap_mis", 32'd1022, 32'h3344_5566, 1'b1);
    tick();
    check_eq("mis_keep_idle", 32'(misaligned), 32'd1);
    check_eq("valid_drop_idle", 32'(instr_valid), 32'd0);
    check_eq("instr_keep_idle", instruction, 32'h3344_5566);

    // Unaligned load that wraps past the top of memory.
    do_load(32'd1023, 32'hA1B2_C3D4, 4'hF);
    do_fetch("ld_wrap_hi", 32'd1020, 32'h1122_33A1, 1'b0);
    do_fetch("ld_wrap_lo", 32'd0, 32'hB2C3_D488, 1'b0);

    // Hold: the outputs freeze while a fetch of address 4 is requested.
    // A load is still accepted during the hold.
    do_load(32'd0, 32'h8020_000A, 4'hF);
    do_fetch("pre_hold", 32'd0, 32'h8020_000A, 1'b0);
    hold = 1'b1;
    fetch_en = 1'b1;
    addr = 32'd4;
    for (int k = 0; k < 3; k++) begin
      ld_en = (k == 1);
      ld_addr = 32'd4;
      ld_data = 32'h0102_0304;
      ld_be = 4'hF;
      tick();
      check_eq("hold_instr", instruction, 32'h8020_000A);
      check_eq("hold_valid", 32'(instr_valid), 32'd1);
    end
    ld_en = 1'b0;
    hold = 1'b0;
    fetch_en = 1'b0;

    // Read-first behaviour when a load and a fetch hit the same word.
    ld_en = 1'b1; ld_addr = 32'd0; ld_data = 32'hDEAD_BEEF; ld_be = 4'hF;
    fetch_en = 1'b1; addr = 32'd0;
    tick();
    ld_en = 1'b0;
    check_eq("read_first_old", instruction, 32'h8020_000A);
    do_fetch("read_first_new", 32'd0, 32'hDEAD_BEEF, 1'b0);
    do_fetch("hold_load", 32'd4, 32'h0102_0304, 1'b0);

    // Reset during an active fetch, then reset again partway through CLEAR.
    fetch_en = 1'b1;
    addr = 32'd0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("midrst_instr", instruction, 32'h0);
    check_eq("midrst_valid", 32'(instr_valid), 32'd0);
    check_eq("midrst_busy", 32'(busy), 32'd1);
    for (int k = 0; k < 99; k++) tick();
    check_eq("clear99_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wait_clear(1'b1, cyc, bad);
    check_eq("reclear_cycles", 32'(cyc), 32'd256);
    check_eq("reclear_idle", 32'(bad), 32'd0);
    do_fetch("after_clear_0", 32'd0, 32'h0, 1'b0);
    do_fetch("after_clear_4", 32'd4, 32'h0, 1'b0);
    do_fetch("dropped_load", 32'd8, 32'h0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
